// File: rtl/spi_xfer_queue.sv
// Transfer queue in front of spi_master: TX FIFO feeds the master one word at a time,
// completion data is captured into an RX FIFO, with post-transfer gap and busy timeout.
module spi_xfer_queue #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int GAP_CYCLES   = 2,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          spi_start_tx,
    output logic [DATA_WIDTH-1:0]         spi_tx_data,
    input  logic                          spi_busy,
    input  logic                          spi_irq,
    input  logic [DATA_WIDTH-1:0]         spi_rx_data,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          timeout_err,
    input  logic                          clr_err
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int CMAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

    logic [DATA_WIDTH-1:0] r_tx_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [LW-1:0]         r_tx_lvl, r_rx_lvl;
    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic                  r_start, w_start_nxt;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_err;
    logic                  w_load, w_tx_pop, w_rx_push, w_to, w_tx_push, w_rx_pop;

    assign wr_ready     = (r_tx_lvl != LW'(FIFO_DEPTH));
    assign rd_valid     = (r_rx_lvl != '0);
    assign rd_data      = rd_valid ? r_rx_mem[r_rx_rp] : '0;
    assign w_tx_push    = wr_valid & wr_ready;
    assign w_rx_pop     = rd_valid & rd_ready;
    assign spi_start_tx = r_start;
    assign spi_tx_data  = r_tx_data;
    assign tx_level     = r_tx_lvl;
    assign rx_level     = r_rx_lvl;
    assign timeout_err  = r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start_nxt = r_start;
        w_load      = 1'b0;
        w_tx_pop    = 1'b0;
        w_rx_push   = 1'b0;
        w_to        = 1'b0;
        case (r_state)
            IDLE: begin
                // RX must have a free slot so the in-flight word always has somewhere to land
                if (enable && r_tx_lvl != '0 && r_rx_lvl != LW'(FIFO_DEPTH)) begin
                    w_state_nxt = ISSUE;
                    w_cnt_nxt   = '0;
                    w_start_nxt = 1'b1;
                    w_load      = 1'b1;
                end
            end
            ISSUE: begin
                if (spi_busy) begin
                    w_tx_pop    = 1'b1;
                    w_start_nxt = 1'b0;
                    w_state_nxt = WAIT_DONE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    w_to        = 1'b1;
                    w_start_nxt = 1'b0;
                    w_state_nxt = GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (spi_irq) begin
                    w_rx_push   = 1'b1;
                    w_state_nxt = GAP;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    w_to        = 1'b1;
                    w_state_nxt = GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                if (r_cnt == CW'(GAP_CYCLES)) w_state_nxt = IDLE;
                else                          w_cnt_nxt   = r_cnt + CW'(1);
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_start   <= 1'b0;
            r_tx_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_start <= w_start_nxt;
            if (w_load) r_tx_data <= r_tx_mem[r_tx_rp];
            if (w_to)         r_err <= 1'b1;
            else if (clr_err) r_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_lvl <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_lvl <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
            if (w_tx_push && !w_tx_pop)      r_tx_lvl <= r_tx_lvl + LW'(1);
            else if (!w_tx_push && w_tx_pop) r_tx_lvl <= r_tx_lvl - LW'(1);
            if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
            if (w_rx_push && !w_rx_pop)      r_rx_lvl <= r_rx_lvl + LW'(1);
            else if (!w_rx_push && w_rx_pop) r_rx_lvl <= r_rx_lvl - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= wr_data;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= spi_rx_data;
    end
endmodule

// File: tb/tb_spi_xfer_queue.sv
// Directed bench for spi_xfer_queue with a behavioural spi_master responder.
module tb_spi_xfer_queue;
    localparam int DW = 8, FD = 16, GAP = 2, BT = 8, IRQ_DLY = 5;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
    logic wr_valid = 1'b0, rd_ready = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic wr_ready, rd_valid, spi_start_tx, timeout_err;
    logic [DW-1:0] rd_data, spi_tx_data;
    logic spi_busy = 1'b0, spi_irq = 1'b0;
    logic [DW-1:0] spi_rx_data = '0;
    logic [4:0] tx_level, rx_level;

    int total = 0, bad = 0;
    int cyc = 0, last_irq = 0, n_starts = 0;
    logic st_q = 1'b0;
    logic m_busy_en = 1'b1, m_irq_en = 1'b1, m_abort = 1'b0;
    int m_st = 0, m_n = 0;
    logic [DW-1:0] m_tx = '0;

    spi_xfer_queue #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .spi_start_tx(spi_start_tx), .spi_tx_data(spi_tx_data),
        .spi_busy(spi_busy), .spi_irq(spi_irq), .spi_rx_data(spi_rx_data),
        .tx_level(tx_level), .rx_level(rx_level),
        .timeout_err(timeout_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        st_q <= spi_start_tx;
        if (spi_irq) last_irq <= cyc;
        if (spi_start_tx && !st_q) n_starts <= n_starts + 1;
    end

    // Master model: busy one cycle after start is seen, irq IRQ_DLY cycles later with ~tx.
    always @(negedge clk) begin
        if (m_abort) begin
            spi_busy = 1'b0; spi_irq = 1'b0; m_st = 0;
        end else begin
            case (m_st)
                0: if (spi_start_tx && m_busy_en) begin m_tx = spi_tx_data; m_st = 1; end
                1: begin spi_busy = 1'b1; m_n = 0; m_st = 2; end
                2: begin
                    m_n++;
                    if (m_n >= IRQ_DLY && m_irq_en) begin
                        spi_irq = 1'b1; spi_rx_data = ~m_tx; m_st = 3;
                    end
                end
                default: begin spi_irq = 1'b0; spi_busy = 1'b0; m_st = 0; end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0: return spi_start_tx;
            1: return rd_valid;
            2: return timeout_err;
            default: return (rx_level == 5'(FD));
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic v, input string tag);
        int n = 0;
        while (probe(sel) !== v && n < 600) begin tick(); n++; end
        chk(tag, 32'(probe(sel)), 32'(v));
    endtask

    task automatic push(input logic [DW-1:0] d);
        int n = 0;
        wr_valid = 1'b1; wr_data = d;
        while (!wr_ready && n < 600) begin tick(); n++; end
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        int n, s0;
        logic [DW-1:0] e;
        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start", 32'(spi_start_tx), 0);
        chk("rst_txd", 32'(spi_tx_data), 0);
        chk("rst_rdv", 32'(rd_valid), 0);
        chk("rst_rdd", 32'(rd_data), 0);
        chk("rst_txl", 32'(tx_level), 0);
        chk("rst_rxl", 32'(rx_level), 0);
        chk("rst_err", 32'(timeout_err), 0);
        rst = 1'b0;
        tick();
        chk("rst_wrr", 32'(wr_ready), 1);

        // single word
        enable = 1'b1;
        push(8'h3C);
        chk("sw_txl1", 32'(tx_level), 1);
        chk("sw_st0", 32'(spi_start_tx), 0);
        tick();
        chk("sw_st1", 32'(spi_start_tx), 1);
        chk("sw_txd", 32'(spi_tx_data), 32'h3C);
        n = 0;
        while (spi_start_tx && n < 50) begin n++; tick(); end
        chk("sw_sthi", 32'(n), 2);
        chk("sw_txl0", 32'(tx_level), 0);
        wait_for(1, 1'b1, "sw_rdv");
        chk("sw_rdd", 32'(rd_data), 32'hC3);
        chk("sw_rxl", 32'(rx_level), 1);
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        chk("sw_rdv0", 32'(rd_valid), 0);
        repeat (10) tick();

        // fill with enable low, then run
        enable = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill_txl", 32'(tx_level), 16);
        chk("fill_wrr", 32'(wr_ready), 0);
        wr_valid = 1'b1; wr_data = 8'hAA; tick(); wr_valid = 1'b0;
        chk("fill_17", 32'(tx_level), 16);
        repeat (3) tick();
        chk("fill_idle", 32'(spi_start_tx), 0);
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_for(0, 1'b1, "fill_st");
            chk("fill_txd", 32'(spi_tx_data), 32'(i));
            chk("fill_gap", 32'(cyc - last_irq >= GAP + 3), 1);
            wait_for(0, 1'b0, "fill_stf");
        end
        wait_for(3, 1'b1, "fill_rxfull");
        chk("fill_txl0", 32'(tx_level), 0);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            e = ~8'(i);
            chk("fill_rdd", 32'(rd_data), 32'(e));
            tick();
        end
        rd_ready = 1'b0;
        chk("fill_rxl0", 32'(rx_level), 0);

        // RX backpressure
        for (int i = 0; i < 20; i++) push(8'(8'h40 + i));
        wait_for(3, 1'b1, "bp_rxfull");
        repeat (30) tick();
        chk("bp_txl", 32'(tx_level), 4);
        chk("bp_st", 32'(spi_start_tx), 0);
        s0 = n_starts;
        repeat (20) tick();
        chk("bp_hold", 32'(n_starts), 32'(s0));
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        repeat (40) tick();
        chk("bp_one", 32'(n_starts), 32'(s0 + 1));
        chk("bp_rxl", 32'(rx_level), 16);
        chk("bp_txl3", 32'(tx_level), 3);
        rd_ready = 1'b1;
        repeat (250) tick();
        rd_ready = 1'b0;
        chk("bp_rxl0", 32'(rx_level), 0);
        chk("bp_txl0", 32'(tx_level), 0);

        // ISSUE timeout, retry of the same word
        m_busy_en = 1'b0;
        push(8'h5A);
        wait_for(0, 1'b1, "to1_st");
        n = 0;
        while (spi_start_tx && n < 50) begin n++; tick(); end
        chk("to1_hi", 32'(n), 8);
        chk("to1_err", 32'(timeout_err), 1);
        chk("to1_txl", 32'(tx_level), 1);
        m_busy_en = 1'b1;
        wait_for(0, 1'b1, "to1_re");
        chk("to1_txd", 32'(spi_tx_data), 32'h5A);
        wait_for(1, 1'b1, "to1_rdv");
        chk("to1_rdd", 32'(rd_data), 32'hA5);
        chk("to1_txl0", 32'(tx_level), 0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("to1_clr", 32'(timeout_err), 0);
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        repeat (6) tick();

        // WAIT_DONE timeout
        m_irq_en = 1'b0;
        push(8'h77);
        wait_for(0, 1'b1, "to2_st");
        wait_for(0, 1'b0, "to2_stf");
        n = 0;
        while (!timeout_err && n < 50) begin n++; tick(); end
        chk("to2_lat", 32'(n), 8);
        chk("to2_err", 32'(timeout_err), 1);
        chk("to2_txl", 32'(tx_level), 0);
        chk("to2_rxl", 32'(rx_level), 0);
        m_abort = 1'b1; tick(); m_abort = 1'b0; m_irq_en = 1'b1;
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        repeat (6) tick();
        chk("to2_rxl2", 32'(rx_level), 0);

        // reset while the master is mid-transfer
        push(8'h11);
        wait_for(0, 1'b1, "rw_st");
        wait_for(0, 1'b0, "rw_stf");
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        chk("rw_st0", 32'(spi_start_tx), 0);
        chk("rw_txd", 32'(spi_tx_data), 0);
        chk("rw_txl", 32'(tx_level), 0);
        repeat (10) tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("rw_rxl", 32'(rx_level), 0);
        chk("rw_rdv", 32'(rd_valid), 0);
        chk("rw_rdd", 32'(rd_data), 0);
        chk("rw_wrr", 32'(wr_ready), 1);
        chk("rw_err", 32'(timeout_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
